// File: rtl/matmul_sp_writeback.sv
// Write-back stage for the systolic matmul array: captures the result matrix on
// the completion pulse and streams the R x C valid elements into a scratchpad slot.
module matmul_sp_writeback #(
    parameter int MAX_DIM     = 4,
    parameter int BUS_WIDTH   = 32,
    parameter int SP_NTARGETS = 4,
    localparam int DIM_W = $clog2(MAX_DIM),
    localparam int TGT_W = $clog2(SP_NTARGETS),
    localparam int SPA_W = $clog2(SP_NTARGETS*MAX_DIM*MAX_DIM)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start_i,
    input  logic [MAX_DIM*MAX_DIM*BUS_WIDTH-1:0] result_i,
    input  logic [DIM_W-1:0]                   rows_m1_i,
    input  logic [DIM_W-1:0]                   cols_m1_i,
    input  logic [TGT_W-1:0]                   sp_target_i,
    input  logic                               sp_ready_i,
    output logic                               sp_we_o,
    output logic [SPA_W-1:0]                   sp_addr_o,
    output logic [BUS_WIDTH-1:0]               sp_wdata_o,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               err_o
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

    state_t               r_state;
    logic [BUS_WIDTH-1:0] r_elem [MAX_DIM*MAX_DIM];
    logic [DIM_W-1:0]     r_row;
    logic [DIM_W-1:0]     r_col;
    logic [DIM_W-1:0]     r_rows_m1;
    logic [DIM_W-1:0]     r_cols_m1;
    logic [TGT_W-1:0]     r_tgt;
    logic                 r_we;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;
    logic [SPA_W-1:0]     r_addr;
    logic [BUS_WIDTH-1:0] r_wdata;

    logic                 w_col_wrap;
    logic                 w_last;
    logic [DIM_W-1:0]     w_next_row;
    logic [DIM_W-1:0]     w_next_col;

    always_comb begin
        w_col_wrap = (r_col == r_cols_m1);
        w_last     = w_col_wrap && (r_row == r_rows_m1);
        w_next_col = w_col_wrap ? '0 : r_col + 1'b1;
        w_next_row = w_col_wrap ? r_row + 1'b1 : r_row;
    end

    // Address/data are registered one step ahead so the port holds stable under backpressure.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_row     <= '0;
            r_col     <= '0;
            r_rows_m1 <= '0;
            r_cols_m1 <= '0;
            r_tgt     <= '0;
            r_we      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            for (int unsigned i = 0; i < MAX_DIM*MAX_DIM; i++) begin
                r_elem[i] <= '0;
            end
        end else begin
            r_err  <= start_i && (r_state != S_IDLE);
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        for (int unsigned i = 0; i < MAX_DIM*MAX_DIM; i++) begin
                            r_elem[i] <= result_i[i*BUS_WIDTH +: BUS_WIDTH];
                        end
                        r_rows_m1 <= rows_m1_i;
                        r_cols_m1 <= cols_m1_i;
                        r_tgt     <= sp_target_i;
                        r_row     <= '0;
                        r_col     <= '0;
                        r_we      <= 1'b1;
                        r_busy    <= 1'b1;
                        r_addr    <= {sp_target_i, {(2*DIM_W){1'b0}}};
                        r_wdata   <= result_i[BUS_WIDTH-1:0];
                        r_state   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (sp_ready_i) begin
                        if (w_last) begin
                            r_we    <= 1'b0;
                            r_busy  <= 1'b0;
                            r_addr  <= '0;
                            r_wdata <= '0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_row   <= w_next_row;
                            r_col   <= w_next_col;
                            r_addr  <= {r_tgt, w_next_row, w_next_col};
                            r_wdata <= r_elem[{w_next_row, w_next_col}];
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign sp_we_o    = r_we;
    assign sp_addr_o  = r_addr;
    assign sp_wdata_o = r_wdata;
    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign err_o      = r_err;

endmodule

// File: tb/tb_matmul_sp_writeback.sv
// Directed bench for matmul_sp_writeback: runs each scenario, records accepted
// writes and pulse timing, then compares against hand-computed values.
module tb_matmul_sp_writeback;

    localparam int MAX_DIM     = 4;
    localparam int BUS_WIDTH   = 32;
    localparam int SP_NTARGETS = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start_i = 1'b0;
    logic [511:0] result_i = '0;
    logic [1:0]   rows_m1_i = '0;
    logic [1:0]   cols_m1_i = '0;
    logic [1:0]   sp_target_i = '0;
    logic         sp_ready_i = 1'b1;
    logic         sp_we_o;
    logic [5:0]   sp_addr_o;
    logic [31:0]  sp_wdata_o;
    logic         busy_o;
    logic         done_o;
    logic         err_o;

    matmul_sp_writeback #(
        .MAX_DIM    (MAX_DIM),
        .BUS_WIDTH  (BUS_WIDTH),
        .SP_NTARGETS(SP_NTARGETS)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .result_i   (result_i),
        .rows_m1_i  (rows_m1_i),
        .cols_m1_i  (cols_m1_i),
        .sp_target_i(sp_target_i),
        .sp_ready_i (sp_ready_i),
        .sp_we_o    (sp_we_o),
        .sp_addr_o  (sp_addr_o),
        .sp_wdata_o (sp_wdata_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] acc_addr [16];
    logic [31:0] acc_data [16];
    int acc_n, done_cyc, n_done, n_busy, n_err, err_cyc, n_hold_bad, n_zero_bad;
    int rdy_pat [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // 0: 0x100*r+c, 1: flat index, 2: corrupted data used to prove late changes are ignored
    task automatic fill(input int kind);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                case (kind)
                    0:       result_i[(r*4+c)*32 +: 32] = 32'(32'h100*r + c);
                    1:       result_i[(r*4+c)*32 +: 32] = 32'(r*4 + c);
                    default: result_i[(r*4+c)*32 +: 32] = 32'hBAD0_0000 | 32'(r*4 + c);
                endcase
            end
        end
    endtask

    // mode 0: plain, 1: second start at cycle 2, 2: reset after 3 accepted writes
    task automatic run(input int rm1, input int cm1, input int tgt, input int ncyc, input int mode);
        logic        stalled;
        logic [5:0]  prev_addr;
        logic [31:0] prev_data;
        acc_n = 0; done_cyc = -1; n_done = 0; n_busy = 0; n_err = 0; err_cyc = -1;
        n_hold_bad = 0; n_zero_bad = 0; stalled = 1'b0; prev_addr = '0; prev_data = '0;
        for (int i = 0; i < 16; i++) begin
            acc_addr[i] = '1;
            acc_data[i] = '1;
        end
        rows_m1_i   = 2'(rm1);
        cols_m1_i   = 2'(cm1);
        sp_target_i = 2'(tgt);
        sp_ready_i  = 1'b1;
        start_i     = 1'b1;
        tick();
        start_i = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            sp_ready_i = (k - 1 < rdy_pat.size()) ? rdy_pat[k-1][0] : 1'b1;
            if (mode == 1 && k == 2) begin
                start_i = 1'b1;
                fill(2);
            end
            if (mode == 1 && k == 3) start_i = 1'b0;
            if (!sp_we_o && (sp_addr_o != '0 || sp_wdata_o != '0)) n_zero_bad++;
            if (stalled && (!sp_we_o || sp_addr_o != prev_addr || sp_wdata_o != prev_data)) n_hold_bad++;
            if (mode == 2 && acc_n == 3) begin
                rst = 1'b0;
                tick();
                check("rst_ctrl", {28'd0, sp_we_o, busy_o, done_o, err_o}, 32'd0);
                check("rst_addr", {26'd0, sp_addr_o}, 32'd0);
                check("rst_data", sp_wdata_o, 32'd0);
                rst = 1'b1;
                tick();
                return;
            end
            if (sp_we_o && sp_ready_i && acc_n < 16) begin
                acc_addr[acc_n] = {26'd0, sp_addr_o};
                acc_data[acc_n] = sp_wdata_o;
                acc_n++;
            end
            if (busy_o) n_busy++;
            if (done_o) begin
                n_done++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (err_o) begin
                n_err++;
                if (err_cyc < 0) err_cyc = k;
            end
            stalled   = sp_we_o && !sp_ready_i;
            prev_addr = sp_addr_o;
            prev_data = sp_wdata_o;
            tick();
        end
        sp_ready_i = 1'b1;
        rdy_pat.delete();
    endtask

    initial begin
        int ea [9];
        int ed [9];

        rst = 1'b0;
        tick();
        tick();
        check("reset_ctrl", {28'd0, sp_we_o, busy_o, done_o, err_o}, 32'd0);
        check("reset_addr", {26'd0, sp_addr_o}, 32'd0);
        check("reset_data", sp_wdata_o, 32'd0);
        rst = 1'b1;
        tick();

        // 2x3 into slot 1
        fill(0);
        run(1, 2, 1, 12, 0);
        ea = '{16, 17, 18, 20, 21, 22, 0, 0, 0};
        ed = '{'h0, 'h1, 'h2, 'h100, 'h101, 'h102, 0, 0, 0};
        check("r23_count", 32'(acc_n), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("r23_addr%0d", i), acc_addr[i], 32'(ea[i]));
            check($sformatf("r23_data%0d", i), acc_data[i], 32'(ed[i]));
        end
        check("r23_done_cyc", 32'(done_cyc), 32'd7);
        check("r23_done_n", 32'(n_done), 32'd1);
        check("r23_busy_n", 32'(n_busy), 32'd6);
        check("r23_err_n", 32'(n_err), 32'd0);
        check("r23_zero", 32'(n_zero_bad), 32'd0);

        // full 4x4 into slot 3
        fill(1);
        run(3, 3, 3, 20, 0);
        check("r44_count", 32'(acc_n), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("r44_addr%0d", i), acc_addr[i], 32'(48 + i));
            check($sformatf("r44_data%0d", i), acc_data[i], 32'(i));
        end
        check("r44_done_cyc", 32'(done_cyc), 32'd17);
        check("r44_busy_n", 32'(n_busy), 32'd16);

        // backpressure 2x2 into slot 0
        fill(0);
        rdy_pat = '{1, 0, 0, 1, 0, 1, 1};
        run(1, 1, 0, 12, 0);
        ea = '{0, 1, 4, 5, 0, 0, 0, 0, 0};
        ed = '{'h0, 'h1, 'h100, 'h101, 0, 0, 0, 0, 0};
        check("bp_count", 32'(acc_n), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp_addr%0d", i), acc_addr[i], 32'(ea[i]));
            check($sformatf("bp_data%0d", i), acc_data[i], 32'(ed[i]));
        end
        check("bp_hold", 32'(n_hold_bad), 32'd0);
        check("bp_done_cyc", 32'(done_cyc), 32'd8);
        check("bp_done_n", 32'(n_done), 32'd1);

        // start while busy: 3x3 into slot 2, result_i corrupted at the second start
        fill(0);
        run(2, 2, 2, 14, 1);
        ea = '{32, 33, 34, 36, 37, 38, 40, 41, 42};
        ed = '{'h0, 'h1, 'h2, 'h100, 'h101, 'h102, 'h200, 'h201, 'h202};
        check("sb_count", 32'(acc_n), 32'd9);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("sb_addr%0d", i), acc_addr[i], 32'(ea[i]));
            check($sformatf("sb_data%0d", i), acc_data[i], 32'(ed[i]));
        end
        check("sb_err_n", 32'(n_err), 32'd1);
        check("sb_err_cyc", 32'(err_cyc), 32'd3);
        check("sb_done_n", 32'(n_done), 32'd1);
        check("sb_done_cyc", 32'(done_cyc), 32'd10);

        // reset mid-run of a 4x4, then 1x1 into slot 2
        fill(1);
        run(3, 3, 3, 20, 2);
        check("mr_count", 32'(acc_n), 32'd3);
        fill(0);
        run(0, 0, 2, 5, 0);
        check("mr11_count", 32'(acc_n), 32'd1);
        check("mr11_addr", acc_addr[0], 32'd32);
        check("mr11_data", acc_data[0], 32'd0);
        check("mr11_done_cyc", 32'(done_cyc), 32'd2);

        // 1x1 into slot 0
        fill(1);
        result_i[31:0] = 32'hCAFE_F00D;
        run(0, 0, 0, 5, 0);
        check("r11_count", 32'(acc_n), 32'd1);
        check("r11_addr", acc_addr[0], 32'd0);
        check("r11_data", acc_data[0], 32'hCAFE_F00D);
        check("r11_done_cyc", 32'(done_cyc), 32'd2);
        check("r11_err_n", 32'(n_err), 32'd0);
        check("r11_zero", 32'(n_zero_bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/matmul_sp_writeback.md
# matmul_sp_writeback

Write-back stage that sits directly downstream of the systolic matrix-multiply array. On the array's completion pulse it captures the flattened result matrix, then streams the valid elements one per cycle into a selected scratchpad slot through a ready-qualified write port shared with the APB read path. On completion it pulses `done_o` toward the register file and golden checker.

## Interface
- `MAX_DIM`, default 4: maximum matrix dimension.
- `BUS_WIDTH`, default 32: width of one result element and of scratchpad data.
- `SP_NTARGETS`, default 4: number of scratchpad matrix slots.
- Derived `DIM_W = $clog2(MAX_DIM)`, `TGT_W = $clog2(SP_NTARGETS)`, `SPA_W = $clog2(SP_NTARGETS*MAX_DIM*MAX_DIM)`.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: reset, synchronous and active-low.
- `start_i` in 1: one-cycle completion pulse from the systolic array.
- `result_i` in `MAX_DIM*MAX_DIM*BUS_WIDTH`: flattened result matrix. Element (r,c) is at bits `[(r*MAX_DIM+c)*BUS_WIDTH +: BUS_WIDTH]`.
- `rows_m1_i` in `DIM_W`: result rows minus 1.
- `cols_m1_i` in `DIM_W`: result columns minus 1.
- `sp_target_i` in `TGT_W`: destination scratchpad slot.
- `sp_ready_i` in 1: scratchpad accepts the current write.
- `sp_we_o` out 1: write request.
- `sp_addr_o` out `SPA_W`: scratchpad element address.
- `sp_wdata_o` out `BUS_WIDTH`: write data.
- `busy_o` out 1: write-back in progress.
- `done_o` out 1: one-cycle completion pulse.
- `err_o` out 1: one-cycle pulse when `start_i` is rejected.

## Operation
- The FSM has three states: IDLE, WRITE, DONE.
- **IDLE**
  - When `start_i`=1: register `result_i`, `rows_m1_i`, `cols_m1_i` and `sp_target_i`; clear row and column counters; go to WRITE.
  - The inputs are sampled only at this point. Later changes to them have no effect on the run in progress.
- **WRITE**
  - `sp_we_o`=1 and `busy_o`=1.
  - `sp_addr_o = tgt*MAX_DIM*MAX_DIM + row*MAX_DIM + col`.
  - `sp_wdata_o` = captured element (row,col).
  - A write is accepted on a cycle where `sp_we_o`&`sp_ready_i` is 1.
  - On acceptance: if `col==cols_m1`, set col=0 and row+=1; otherwise col+=1.
  - Acceptance of the element at (rows_m1, cols_m1) moves the FSM to DONE.
  - Elements outside rows×cols are never written. Addresses of unused slot entries are untouched.
- **DONE**
  - `done_o`=1 and `busy_o`=0 for one cycle, then return to IDLE.
- **start_i while in WRITE or DONE**
  - The start is ignored: no capture, no state change.
  - `err_o` pulses the following cycle.
- Counters are `DIM_W` bits. The `*MAX_DIM` terms are power-of-two shifts. No arithmetic overflow is possible within the parameter ranges.

## Timing
- **Reset values:** all outputs are 0; state is IDLE; counters and captured registers are 0.
- **Reset mid-operation:** the run aborts. The cycle after `rst` is sampled low, `sp_we_o`, `busy_o`, `done_o` and `err_o` are all 0. No resumption occurs.
- **Latency with `sp_ready_i` held at 1:**
  - `start_i` is sampled at edge 0.
  - The first `sp_we_o` appears after edge 0.
  - The run takes R×C write cycles.
  - `done_o` is high in the cycle following the last accepted write.
  - `start_i` to `done_o` = R×C+1 cycles.
- **Backpressure:** while `sp_ready_i`=0, `sp_we_o`, `sp_addr_o` and `sp_wdata_o` hold stable. Each stalled cycle adds one cycle of latency.
- **Earliest restart:** a new `start_i` is accepted in the cycle after `done_o`, which is back in IDLE. This gives a back-to-back throughput of one matrix per R×C+2 cycles.
- `sp_addr_o` and `sp_wdata_o` are 0 whenever `sp_we_o`=0.

## Test plan
All scenarios use `MAX_DIM`=4, `BUS_WIDTH`=32, `SP_NTARGETS`=4.

- **2×3 run, slot 1:** element (r,c)=`32'h100*r+c`, target 1, ready=1. Required writes: addr 16,17,18,20,21,22 with data 0,1,2,100,101,102 (hex). `done_o` appears 7 cycles after start. `busy_o` is high for 6 cycles.
- **Full 4×4 run, slot 3:** ready=1. Required: addr 48..63 in order, data equal to the flat index. `done_o` appears at cycle 17.
- **Backpressure:** 2×2 run, slot 0, `sp_ready_i` pattern 1,0,0,1,0,1,1. Required: addr/data held during zeros, addresses 0,1,4,5 each accepted exactly once, `done_o` after the 4th acceptance.
- **Start while busy:** second `start_i` two cycles into a 3×3 run, with `result_i` changed at that moment. Required: `err_o` pulses once, the write sequence is unchanged and uses the original data, exactly one `done_o`.
- **Reset mid-run:** `rst`=0 after 3 accepted writes of a 4×4 run. Required: all outputs 0 on the next cycle. A following 1×1 run to slot 2 writes addr 32 and raises `done_o` at cycle 2.
- **1×1 run, slot 0:** Required: a single write to addr 0, `done_o` at cycle 2, no `err_o`.
